fetch_unit: RTL and testbench

Parametrised instruction-fetch stage with an in-order prefetch queue. Issues sequential fetch requests to the instruction memory over a valid/ready request channel, accepts in-order responses of arbitrary latency, and buffers fetched instructions with their PCs in a DEPTH-entry queue feeding decode through a valid/ready handshake. A redirect from execute (branch/jump) flushes the queue and discards in-flight responses. This is the next-generation fetch stage: it adds a prefetch queue, backpressure and redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Entry layout is {pc, instr}, head-of-queue first.
package fetch_pkg;

  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Flush wins over push and pop in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Data array needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  assign head  = mem[rptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with prefetch queue, credit-limited
// requests and redirect flush of in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   nrst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [ILEN-1:0]        imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_instr,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + ILEN;

  fetch_state_e state;
  fetch_state_e state_nx;
  logic         run;

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_nx;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   occ;
  logic [CW:0]     credit;
  logic            acc;
  logic            resp;
  logic            push;
  logic            pop;
  logic            head_vld;
  logic [EW-1:0]   head;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_RESET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RESET: state_nx = ST_RUN;
      ST_RUN:   state_nx = ST_RUN;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state)
      ST_RESET: run = 1'b0;
      ST_RUN:   run = 1'b1;
    endcase
  end

  // Queued plus outstanding never exceeds DEPTH, so pushes always fit.
  assign credit = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = run && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = req_pc;

  assign acc      = imem_req_valid && imem_req_ready;
  assign resp     = imem_resp_valid;
  assign head_vld = (occ != '0);
  assign push     = resp && (drop == '0) && !redirect_valid;
  assign pop      = head_vld && out_ready && !redirect_valid;
  assign outst_nx = outst + CW'(acc) - CW'(resp);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_pc  <= RESET_PC;
      resp_pc <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
    end else begin
      outst <= outst_nx;
      if (redirect_valid) begin
        req_pc  <= redirect_pc;
        resp_pc <= redirect_pc;
        drop    <= outst_nx;
      end else begin
        if (acc)  req_pc  <= req_pc + XLEN'(PC_STEP);
        if (push) resp_pc <= resp_pc + XLEN'(PC_STEP);
        if (resp && drop != '0) drop <= drop - 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .din   ({resp_pc, imem_resp_data}),
    .pop   (pop),
    .flush (redirect_valid),
    .count (occ),
    .head  (head)
  );

  assign out_valid = head_vld;
  assign out_pc    = head_vld ? head[EW-1:ILEN] : '0;
  assign out_instr = head_vld ? head[ILEN-1:0]  : '0;
  assign occupancy = occ;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level
// model: in-flight list with stale tags plus an output queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int D = 4;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  fetch_unit #(
    .XLEN(32), .ILEN(32), .DEPTH(D), .RESET_PC(RPC)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  bit           m_run;
  logic [31:0]  m_pc;
  fetch_entry_t m_q[$];
  infl_t        m_inf[$];
  mreq_t        mem[$];
  int           cyc = 0;

  task automatic model_reset();
    m_run = 1'b0;
    m_pc  = RPC;
    m_q.delete();
    m_inf.delete();
    mem.delete();
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    out_ready       = 1'b0;
  endtask

  // Release reset on a falling edge; the next rising edge starts RUN.
  task automatic release_reset();
    @(negedge clk);
    nrst = 1'b1;
    idle_inputs();
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, RPC);
    m_run = 1'b1;
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    r = $urandom;
    case (r[3:2])
      2'd0: return 32'h0000_0100;
      2'd1: return 32'hFFFF_FFF8;
      default: return {r[31:4], 4'h0};
    endcase
  endfunction

  task automatic step(input int pr, input int po, input int pd,
                      input int lmin, input int lmax);
    bit          ev;
    bit          rsp;
    infl_t       e;
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    ev = m_run && (m_q.size() + m_inf.size() < D);
    check("req_valid", 32'(imem_req_valid), 32'(ev));
    if (ev) check("req_addr", imem_req_addr, m_pc);
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("occupancy", 32'(occupancy), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_instr", out_instr, m_q[0].instr);
    end
    imem_req_ready = ($urandom_range(99) < pr);
    out_ready      = ($urandom_range(99) < po);
    redirect_valid = ($urandom_range(99) < pd);
    redirect_pc    = pick_pc();
    rsp = (mem.size() != 0) && (mem[0].due <= cyc);
    imem_resp_valid = rsp;
    imem_resp_data  = $urandom;
    if (rsp) begin
      a = mem[0].addr;
      imem_resp_data = hash(a);
      void'(mem.pop_front());
    end
    if (imem_req_valid && imem_req_ready)
      mem.push_back('{imem_req_addr, cyc + $urandom_range(lmax, lmin)});
    if (!redirect_valid && out_ready && m_q.size() != 0)
      void'(m_q.pop_front());
    if (rsp && m_inf.size() != 0) begin
      e = m_inf.pop_front();
      if (!e.stale && !redirect_valid)
        m_q.push_back('{e.pc, hash(e.pc)});
    end
    if (ev && imem_req_ready) begin
      m_inf.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      m_q.delete();
      foreach (m_inf[i]) m_inf[i].stale = 1'b1;
      m_pc = redirect_pc;
    end
    m_run = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    idle_inputs();
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_occupancy", 32'(occupancy), 0);
    check("reset_out_pc", out_pc, 0);
    check("reset_out_instr", out_instr, 0);
    #20;
    release_reset();

    // streaming, 1-cycle latency, always ready; wraps past 0
    repeat (30) step(100, 100, 0, 1, 1);
    // decode stalled: queue fills, requests stop
    repeat (12) step(100, 0, 0, 1, 1);
    repeat (6)  step(100, 100, 0, 1, 1);
    // long latency with redirects against in-flight fetches
    repeat (200) step(100, 50, 10, 3, 3);
    // fully random traffic
    repeat (3000) step(70, 60, 5, 1, 5);

    // fill the queue, then reset between clock edges
    n = 0;
    while (m_q.size() != D && n < 60) begin
      step(100, 0, 0, 1, 2);
      n++;
    end
    check("fill_depth", 32'(m_q.size()), D);
    #2;
    nrst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_req_valid", 32'(imem_req_valid), 0);
    check("async_occupancy", 32'(occupancy), 0);
    check("async_req_addr", imem_req_addr, RPC);
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (400) step(80, 70, 4, 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
